// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and access-legality check for the LSU memory master.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] MEM_LS_WORD = 2'b10;

  // Unknown funct3, natural misalignment or an address past the end of RAM.
  function automatic logic access_err(input logic        is_store,
                                      input logic [2:0]  f3,
                                      input logic [31:0] addr,
                                      input logic [31:0] mem_bytes);
    logic bad_f3;
    logic misaligned;
    if (is_store) begin
      bad_f3 = (f3 > F3_W);
    end else begin
      bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    case (f3)
      F3_H, F3_HU: misaligned = addr[0];
      F3_W:        misaligned = (addr[1:0] != 2'b00);
      default:     misaligned = 1'b0;
    endcase
    return bad_f3 || misaligned || (addr >= mem_bytes);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: load extract with sign/zero extension and store merge into a RAM word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Load path: select the addressed lane and extend it to 32 bits.
  always_comb begin
    byte_s = word_i[{lane_i, 3'b000} +: 8];
    half_s = word_i[{lane_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    load_o = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_o = {24'h00_0000, byte_s};
      F3_H:    load_o = {{16{half_s[15]}}, half_s};
      F3_HU:   load_o = {16'h0000, half_s};
      default: load_o = word_i;
    endcase
  end

  // Store path: overwrite only the addressed lane, keep the neighbouring bytes.
  always_comb begin
    store_o = word_i;
    case (funct3_i)
      F3_B:    store_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
      F3_H:    store_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: store_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// RV32I load/store sequencer driving a word-wide RAM; sub-word stores are read-modify-write.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wData,
  output logic [1:0]  mem_LSControl,
  output logic        mem_SignControl,
  input  logic [31:0] mem_rData
);

  lsu_state_t  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] load_word_s;
  logic [31:0] store_word_s;

  // The RAM read word is consumed directly in READ, so it feeds the aligner unregistered.
  lsu_lane_align u_align (
    .word_i   (mem_rData),
    .wdata_i  (wdata_q),
    .lane_i   (lane_q),
    .funct3_i (funct3_q),
    .load_o   (load_word_s),
    .store_o  (store_word_s)
  );

  // Next-state, request latch and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          lane_d     = addr[1:0];
          wdata_d    = wdata;
          mem_addr_d = {addr[31:2], 2'b00};
          if (access_err(is_store, funct3, addr, 32'(MEM_BYTES))) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = 32'h0000_0000;
          end else if (is_store && (funct3 == F3_W)) begin
            state_d     = WRITE;
            mem_wdata_d = wdata;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (is_store_q) begin
          state_d     = WRITE;
          mem_wdata_d = store_word_s;
        end else begin
          state_d = DONE;
          rdata_d = load_word_s;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    mem_we_d = (state_d == WRITE);
  end

  // State and output registers; reset aborts any access and drops mem_we at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
      wdata_q     <= 32'h0000_0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign rdata           = rdata_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wData       = mem_wdata_q;
  assign mem_LSControl   = MEM_LS_WORD;
  assign mem_SignControl = 1'b0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized bench for lsu_mem_master with a 64-word RAM and an access-level reference model.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err, mem_we, mem_SignControl;
  logic [31:0] rdata, mem_addr, mem_wData, mem_rData;
  logic [1:0]  mem_LSControl;

  logic [31:0] ram [0:63];
  logic [31:0] model_mem [0:63];
  logic [31:0] model_rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  // Expectations for the access in flight, consumed by the per-cycle compare process
  bit          active = 1'b0;
  bit          manual = 1'b0;
  int          k_cnt = 0;
  int          exp_lat = 0;
  logic        exp_err = 1'b0;
  logic        exp_store_ok = 1'b0;
  logic [31:0] exp_wword = 32'h0;
  logic [31:0] exp_new_rdata = 32'h0;
  logic [31:0] exp_aligned = 32'h0;

  lsu_mem_master #(.MEM_BYTES(256)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wData(mem_wData),
    .mem_LSControl(mem_LSControl), .mem_SignControl(mem_SignControl), .mem_rData(mem_rData)
  );

  always #5 clk = ~clk;

  assign mem_rData = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wData;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (active) begin
      k_cnt = k_cnt + 1;
      chk("busy", busy, k_cnt <= exp_lat);
      chk("done", done, k_cnt == exp_lat);
      chk("err", err, (k_cnt == exp_lat) && exp_err);
      chk("mem_we", mem_we, exp_store_ok && (k_cnt == exp_lat - 1));
      if (k_cnt <= exp_lat) chk("mem_addr", mem_addr, exp_aligned);
      if (exp_store_ok && (k_cnt == exp_lat - 1)) chk("mem_wData", mem_wData, exp_wword);
      chk("rdata", rdata, (k_cnt >= exp_lat) ? exp_new_rdata : model_rdata);
      if (k_cnt > exp_lat) active = 1'b0;
    end else if (reset_n && !manual) begin
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
      chk("idle_we", mem_we, 1'b0);
      chk("idle_rdata", rdata, model_rdata);
      chk("ls_ctrl", {mem_SignControl, mem_LSControl}, 3'b010);
    end
  end

  task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input bit hold);
    int unsigned sz, off, idx;
    logic        e;
    logic [31:0] w, v, nw;
    idx = a[7:2];
    off = a[1:0];
    w   = model_mem[idx];
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e   = (a >= 32'd256) || (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) ||
          ((a % sz) != 0);
    v = w >> (8 * off);
    if (sz == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    nw = w;
    for (int b = 0; b < sz; b++) nw[8*(off+b) +: 8] = wd[8*b +: 8];
    exp_lat       = e ? 1 : (st ? ((sz == 4) ? 2 : 3) : 2);
    exp_err       = e;
    exp_store_ok  = st && !e;
    exp_wword     = nw;
    exp_new_rdata = e ? 32'h0 : (st ? model_rdata : v);
    exp_aligned   = {a[31:2], 2'b00};

    @(negedge clk);
    is_store = st; funct3 = f3; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    addr = $urandom; wdata = $urandom; funct3 = 3'($urandom_range(0, 7));
    k_cnt = 0;
    active = 1'b1;
    for (int t = 0; t < 12 && active; t++) begin
      @(negedge clk);
      #1;
    end
    req = 1'b0;
    if (active) begin
      checks++; failures++;
      $display("FAIL timeout: access still open after 12 cycles");
      active = 1'b0;
    end
    if (st && !e) model_mem[idx] = nw;
    model_rdata = exp_new_rdata;
    chk("ram_word", ram[idx], model_mem[idx]);
    if (e) begin
      int bad;
      bad = 0;
      for (int i = 0; i < 64; i++) if (ram[i] !== model_mem[i]) bad++;
      chk("ram_unchanged", bad, 0);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    ram[idx] = val;
    model_mem[idx] = val;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) set_word(i, $urandom);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wData, 32'h0);
    reset_n = 1'b1;

    set_word(1, 32'h8899AABB);
    set_word(2, 32'h11223344);
    do_access(1'b0, 3'd0, 32'h05, 32'h0, 1'b0);
    chk("lit_lb", rdata, 32'hFFFFFFAA);
    do_access(1'b0, 3'd5, 32'h06, 32'h0, 1'b0);
    chk("lit_lhu", rdata, 32'h00008899);
    do_access(1'b0, 3'd1, 32'h06, 32'h0, 1'b1);
    chk("lit_lh", rdata, 32'hFFFF8899);
    do_access(1'b0, 3'd2, 32'h04, 32'h0, 1'b0);
    chk("lit_lw", rdata, 32'h8899AABB);
    do_access(1'b1, 3'd0, 32'h09, 32'h000000EE, 1'b0);
    chk("lit_sb", ram[2], 32'h1122EE44);
    set_word(2, 32'h11223344);
    do_access(1'b1, 3'd1, 32'h0A, 32'h0000CAFE, 1'b0);
    chk("lit_sh", ram[2], 32'hCAFE3344);
    do_access(1'b1, 3'd2, 32'h08, 32'hDEADBEEF, 1'b0);
    chk("lit_sw", ram[2], 32'hDEADBEEF);
    chk("lit_rdata_kept", rdata, 32'h8899AABB);
    do_access(1'b0, 3'd2, 32'h06, 32'h0, 1'b0);
    chk("lit_err_lw", rdata, 32'h0);
    do_access(1'b1, 3'd1, 32'h03, 32'h1234, 1'b0);
    do_access(1'b0, 3'd0, 32'h100, 32'h0, 1'b0);
    do_access(1'b0, 3'd3, 32'h00, 32'h0, 1'b0);
    chk("lit_err_f3", rdata, 32'h0);

    // Reset asserted while an SB is in its WRITE cycle
    manual = 1'b1;
    @(negedge clk);
    is_store = 1'b1; funct3 = 3'd0; addr = 32'h0; wdata = 32'h5A; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_we_before", mem_we, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_we", mem_we, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_rdata = 32'h0;
    chk("rst_mid_ram", ram[0], model_mem[0]);
    manual = 1'b0;
    do_access(1'b0, 3'd2, 32'h00, 32'h0, 1'b0);
    chk("rst_mid_lw", rdata, model_mem[0]);

    for (int n = 0; n < 300; n++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (st && $urandom_range(0, 3) != 0) f3 = f3 % 3'd3;
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) a = a + 32'h100 * 32'($urandom_range(1, 4));
      do_access(st, f3, a, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
